// File: rtl/bus_ram_slave_pkg.sv
// Shared bus definitions for the RAM target: transfer-mode encodings, FSM state
// encodings and the helper that picks the response state for a captured mode.
package bus_ram_slave_pkg;

    localparam logic BUS_MODE_READ  = 1'b0;
    localparam logic BUS_MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRESP = 2'd2,
        ST_RRESP = 2'd3
    } state_t;

    function automatic state_t resp_state(input logic mode);
        return (mode == BUS_MODE_WRITE) ? ST_WRESP : ST_RRESP;
    endfunction

endpackage

// File: rtl/bus_ram_slave_sp_ram.sv
// Single-port synchronous RAM, 32 x 2**ADDR_W, registered read with enable.
// The array has no reset; contents survive bus resets.
module bus_ram_slave_sp_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_ram_slave.sv
// Word-addressed RAM target with programmable wait states and valid/ready read return.
// Optional BUS_err port for out-of-range accesses when BUS_RAM_OOR_ERR_EN is defined.
module bus_ram_slave
    import bus_ram_slave_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BUS_valid,
    input  logic        BUS_mode,
    input  logic [31:0] BUS_addr,
    input  logic [31:0] BUS_wdata,
    output logic        BUS_wready,
    output logic        BUS_rvalid,
    input  logic        BUS_rready,
    output logic [31:0] BUS_rdata
`ifdef BUS_RAM_OOR_ERR_EN
    ,
    output logic        BUS_err
`endif
);

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              mode_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              in_range_q;
    logic              rdata_zero;
    logic [31:0]       ram_rdata;

    logic              accept;
    logic              live_in_range;
    logic              entry_in_range;
    logic [ADDR_W-1:0] ram_idx;
    logic              ram_we;
    logic              ram_re;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^BUS_addr[1:0];

    assign accept         = (state == ST_IDLE) && BUS_valid;
    assign live_in_range  = (BUS_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign entry_in_range = accept ? live_in_range : in_range_q;

    // With zero wait states the read issues on the accept edge, so the RAM
    // address must bypass the capture register in that cycle.
    assign ram_idx = accept ? BUS_addr[ADDR_W+1:2] : idx_q;
    assign ram_we  = (state == ST_WRESP) && in_range_q && !rst;
    assign ram_re  = (state_nxt == ST_RRESP) && (state != ST_RRESP) && !rst;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (BUS_valid) begin
                    cnt_nxt   = 8'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES == 0) ? resp_state(BUS_mode) : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt <= 8'd1) state_nxt = resp_state(mode_q);
            end
            ST_WRESP: state_nxt = ST_IDLE;
            ST_RRESP: if (BUS_rready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            rdata_zero <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (ram_re) rdata_zero <= !entry_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q     <= BUS_mode;
            idx_q      <= BUS_addr[ADDR_W+1:2];
            wdata_q    <= BUS_wdata;
            in_range_q <= live_in_range;
        end
    end

    bus_ram_slave_sp_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign BUS_wready = (state == ST_WRESP);
    assign BUS_rvalid = (state == ST_RRESP);
    assign BUS_rdata  = rdata_zero ? 32'h0000_0000 : ram_rdata;

`ifdef BUS_RAM_OOR_ERR_EN
    assign BUS_err = ((state == ST_WRESP) || (state == ST_RRESP)) && !in_range_q;
`endif

endmodule

// File: tb/tb_bus_ram_slave.sv
// Bench for bus_ram_slave: two instances (2 wait states / 1K words, 0 wait states / 256 words)
// checked against an array model of the memory window.
module tb_bus_ram_slave;

    logic        clk;
    logic        rst    [2];
    logic        valid  [2];
    logic        mode   [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        wready [2];
    logic        rvalid [2];
    logic        rready [2];
    logic [31:0] rdata  [2];
`ifdef BUS_RAM_OOR_ERR_EN
    logic        err    [2];
`endif

    int tests;
    int fails;

    localparam int AW0 = 10;
    localparam int AW1 = 8;
    int aw_of   [2] = '{AW0, AW1};
    int wait_of [2] = '{2, 0};

    logic [31:0] mem_m [2][1024];
    bit          known [2][1024];

    bus_ram_slave #(.ADDR_W(AW0), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst[0]), .BUS_valid(valid[0]), .BUS_mode(mode[0]),
        .BUS_addr(addr[0]), .BUS_wdata(wdata[0]), .BUS_wready(wready[0]),
        .BUS_rvalid(rvalid[0]), .BUS_rready(rready[0]), .BUS_rdata(rdata[0])
`ifdef BUS_RAM_OOR_ERR_EN
        , .BUS_err(err[0])
`endif
    );

    bus_ram_slave #(.ADDR_W(AW1), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .rst(rst[1]), .BUS_valid(valid[1]), .BUS_mode(mode[1]),
        .BUS_addr(addr[1]), .BUS_wdata(wdata[1]), .BUS_wready(wready[1]),
        .BUS_rvalid(rvalid[1]), .BUS_rready(rready[1]), .BUS_rdata(rdata[1])
`ifdef BUS_RAM_OOR_ERR_EN
        , .BUS_err(err[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit in_win(input int d, input logic [31:0] a);
        return a < (32'd4 << aw_of[d]);
    endfunction

    function automatic int widx(input int d, input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << aw_of[d]) - 1));
    endfunction

    // Issue one transaction and observe it; returns latency (0 = timed out).
    task automatic run_txn(input int d, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int hold,
                           output int lat, output bit resp_wr, output logic [31:0] rd,
                           output logic er, output bit tail_ok, output bit stable_ok);
        valid[d] = 1'b1; mode[d] = wr; addr[d] = a; wdata[d] = wd; rready[d] = 1'b0;
        @(posedge clk); #1;
        valid[d] = 1'b0; mode[d] = ~wr; addr[d] = $urandom; wdata[d] = $urandom;
        lat = 0; resp_wr = 1'b0; rd = '0; er = 1'b0; tail_ok = 1'b1; stable_ok = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            if (wready[d] || rvalid[d]) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) return;
        if (wready[d] && rvalid[d]) tail_ok = 1'b0;
        resp_wr = wready[d];
        rd = rdata[d];
`ifdef BUS_RAM_OOR_ERR_EN
        er = err[d];
`endif
        if (resp_wr) begin
            @(posedge clk); #1;
            if (wready[d] || rvalid[d]) tail_ok = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (!rvalid[d] || rdata[d] !== rd) stable_ok = 1'b0;
`ifdef BUS_RAM_OOR_ERR_EN
                if (err[d] !== er) stable_ok = 1'b0;
`endif
            end
            rready[d] = 1'b1;
            @(posedge clk); #1;
            rready[d] = 1'b0;
            if (rvalid[d] || wready[d]) tail_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b1; mode[d] = 1'b0; addr[d] = 32'h10;
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                tests++; if (wready[d] !== 1'b0) begin fails++; $display("FAIL reset_wready dut%0d got %b want 0", d, wready[d]); end
                tests++; if (rvalid[d] !== 1'b0) begin fails++; $display("FAIL reset_rvalid dut%0d got %b want 0", d, rvalid[d]); end
                tests++; if (rdata[d] !== 32'h0) begin fails++; $display("FAIL reset_rdata dut%0d got %h want 0", d, rdata[d]); end
`ifdef BUS_RAM_OOR_ERR_EN
                tests++; if (err[d] !== 1'b0) begin fails++; $display("FAIL reset_err dut%0d got %b want 0", d, err[d]); end
`endif
            end
        end
        for (int d = 0; d < 2; d++) begin rst[d] = 1'b0; valid[d] = 1'b0; end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (wready[d] !== 1'b0 || rvalid[d] !== 1'b0) begin
                    fails++; $display("FAIL post_reset_idle dut%0d got wready=%b rvalid=%b want 0 0", d, wready[d], rvalid[d]);
                end
            end
        end
    endtask

    task automatic test_write_read_timing();
        int lat; bit rw, tl, st; logic [31:0] rd; logic er;
        run_txn(0, 1'b1, 32'h10, 32'h1234_5678, 0, lat, rw, rd, er, tl, st);
        mem_m[0][4] = 32'h1234_5678; known[0][4] = 1'b1;
        tests++; if (lat != 3) begin fails++; $display("FAIL wr_latency got %0d want 3", lat); end
        tests++; if (rw !== 1'b1) begin fails++; $display("FAIL wr_resp_kind got rvalid want wready"); end
        tests++; if (!tl) begin fails++; $display("FAIL wr_single_pulse got extra response cycle want one"); end
        run_txn(0, 1'b0, 32'h10, 32'h0, 0, lat, rw, rd, er, tl, st);
        tests++; if (lat != 3) begin fails++; $display("FAIL rd_latency got %0d want 3", lat); end
        tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL rd_data got %h want 12345678", rd); end
        tests++; if (!tl) begin fails++; $display("FAIL rd_complete got rvalid still high want low"); end
    endtask

    task automatic test_rready_hold();
        int lat; bit rw, tl, st; logic [31:0] rd; logic er;
        run_txn(0, 1'b0, 32'h13, 32'h0, 5, lat, rw, rd, er, tl, st);
        tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL hold_data got %h want 12345678", rd); end
        tests++; if (!st) begin fails++; $display("FAIL hold_stable got changed want stable for 5 cycles"); end
        tests++; if (!tl) begin fails++; $display("FAIL hold_complete got rvalid high want low after handshake"); end
    endtask

    task automatic test_back_to_back();
        valid[1] = 1'b1; mode[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        tests++; if (wready[1] !== 1'b1) begin fails++; $display("FAIL b2b_wready got %b want 1 at N+1", wready[1]); end
        mode[1] = 1'b0; wdata[1] = 32'h0;
        @(posedge clk); #1;
        tests++;
        if (wready[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
            fails++; $display("FAIL b2b_gap got wready=%b rvalid=%b want 0 0 at N+2", wready[1], rvalid[1]);
        end
        @(posedge clk); #1;
        valid[1] = 1'b0;
        tests++; if (rvalid[1] !== 1'b1) begin fails++; $display("FAIL b2b_rvalid got %b want 1 at N+3", rvalid[1]); end
        tests++; if (rdata[1] !== 32'hA5A5_A5A5) begin fails++; $display("FAIL b2b_rdata got %h want a5a5a5a5", rdata[1]); end
        rready[1] = 1'b1;
        @(posedge clk); #1;
        rready[1] = 1'b0;
        tests++; if (rvalid[1] !== 1'b0) begin fails++; $display("FAIL b2b_done got rvalid=%b want 0", rvalid[1]); end
        mem_m[1][8] = 32'hA5A5_A5A5; known[1][8] = 1'b1;
    endtask

    task automatic test_out_of_range();
        int lat; bit rw, tl, st; logic [31:0] rd; logic er;
        run_txn(0, 1'b1, 32'h0, 32'h0BAD_F00D, 0, lat, rw, rd, er, tl, st);
        mem_m[0][0] = 32'h0BAD_F00D; known[0][0] = 1'b1;
        run_txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 0, lat, rw, rd, er, tl, st);
        tests++; if (lat != 3 || rw !== 1'b1) begin fails++; $display("FAIL oor_wready got lat=%0d wr=%b want 3 1", lat, rw); end
`ifdef BUS_RAM_OOR_ERR_EN
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL oor_wr_err got %b want 1", er); end
`endif
        run_txn(0, 1'b0, 32'h0, 32'h0, 1, lat, rw, rd, er, tl, st);
        tests++; if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL oor_no_alias got %h want 0badf00d", rd); end
`ifdef BUS_RAM_OOR_ERR_EN
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL inrange_err got %b want 0", er); end
`endif
        run_txn(0, 1'b0, 32'h1000, 32'h0, 0, lat, rw, rd, er, tl, st);
        tests++; if (lat != 3 || rd !== 32'h0) begin fails++; $display("FAIL oor_read got lat=%0d data=%h want 3 00000000", lat, rd); end
`ifdef BUS_RAM_OOR_ERR_EN
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL oor_rd_err got %b want 1", er); end
`endif
    endtask

    task automatic test_reset_abort();
        int lat; bit rw, tl, st; logic [31:0] rd; logic er;
        bit seen;
        run_txn(0, 1'b1, 32'h40, 32'h1111_1111, 0, lat, rw, rd, er, tl, st);
        mem_m[0][16] = 32'h1111_1111; known[0][16] = 1'b1;
        valid[0] = 1'b1; mode[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (wready[0] || rvalid[0]) seen = 1'b1;
            @(posedge clk); #1;
        end
        tests++; if (seen) begin fails++; $display("FAIL abort_no_resp got response want none"); end
        run_txn(0, 1'b0, 32'h40, 32'h0, 0, lat, rw, rd, er, tl, st);
        tests++; if (rd !== 32'h1111_1111) begin fails++; $display("FAIL abort_kept got %h want 11111111", rd); end
    endtask

    task automatic test_random();
        int lat; bit rw, tl, st; logic [31:0] rd; logic er;
        for (int i = 0; i < 80; i++) begin
            int d; bit wr; logic [31:0] a, wd; int hold; bit inr; int ix;
            d    = i % 2;
            wr   = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0001_0000) : 32'($urandom_range(0, 127));
            wd   = $urandom;
            hold = $urandom_range(0, 3);
            inr  = in_win(d, a);
            ix   = widx(d, a);
            run_txn(d, wr, a, wd, hold, lat, rw, rd, er, tl, st);
            tests++;
            if (lat != wait_of[d] + 1 || rw !== wr) begin
                fails++; $display("FAIL rnd_timing dut%0d #%0d got lat=%0d wr=%b want %0d %b", d, i, lat, rw, wait_of[d] + 1, wr);
            end
            tests++;
            if (!tl || !st) begin fails++; $display("FAIL rnd_handshake dut%0d #%0d got tail=%b stable=%b want 1 1", d, i, tl, st); end
`ifdef BUS_RAM_OOR_ERR_EN
            tests++;
            if (er !== !inr) begin fails++; $display("FAIL rnd_err dut%0d #%0d got %b want %b", d, i, er, !inr); end
`endif
            if (wr) begin
                if (inr) begin mem_m[d][ix] = wd; known[d][ix] = 1'b1; end
            end else if (!inr) begin
                tests++;
                if (rd !== 32'h0) begin fails++; $display("FAIL rnd_oor_data dut%0d addr %h got %h want 0", d, a, rd); end
            end else if (known[d][ix]) begin
                tests++;
                if (rd !== mem_m[d][ix]) begin fails++; $display("FAIL rnd_data dut%0d addr %h got %h want %h", d, a, rd, mem_m[d][ix]); end
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; valid[d] = 1'b0; mode[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; rready[d] = 1'b0;
            for (int j = 0; j < 1024; j++) begin known[d][j] = 1'b0; mem_m[d][j] = '0; end
        end
        @(posedge clk); #1;
        test_reset();
        test_write_read_timing();
        test_rready_hold();
        test_back_to_back();
        test_out_of_range();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
